// File: rtl/ras_event_queue.sv
// Return-address-stack producer: classifies fetched CALL/RETURN instructions, keeps them in order
// and replays them as registered commits at writeback. Define RAS_EVQ_RVC_EN to decode 16-bit RVC jumps.
module ras_event_queue #(
  parameter int Q_SIZE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fch_valid,
  output logic              fch_ready,
  input  logic [31:0]       fch_insn,
  input  logic [31:0]       fch_pc,
  output logic              fch_predict_call,
  output logic              fch_predict_ret,
  output logic [31:0]       fch_link_addr,
  input  logic              wrb_retire,
  input  logic              wrb_restart_in,
  output logic              wrb_commit_call,
  output logic              wrb_commit_ret,
  output logic [31:0]       wrb_link_addr,
  output logic              wrb_restart,
  output logic [Q_SIZE:0]   q_count,
  output logic              q_underflow
);

  localparam int DEPTH = 1 << Q_SIZE;
  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_CALL = 2'b01;
  localparam logic [1:0] CLS_RET  = 2'b10;

  logic [Q_SIZE-1:0] head_r;
  logic [Q_SIZE-1:0] tail_r;
  logic [Q_SIZE:0]   count_r;
  logic [32:0]       mem_r [0:DEPTH-1];

  logic [1:0]  cls_s;
  logic [31:0] link_s;
  logic [31:0] pc_even_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        rd_link_s;
  logic        rs1_link_s;
  logic        full_s;
  logic        empty_s;
  logic        accept_s;
  logic        retire_ok_s;
  logic        underflow_s;
  logic [32:0] head_entry_s;
  logic [1:0]  head_cls_s;
  logic [30:0] head_link_s;
  logic [Q_SIZE:0] count_next_s;
  logic        unused_s;

  // The low pc bit never contributes to a link address, and the upper immediate bits never affect the class.
  assign unused_s = ^{fch_pc[0], fch_insn[31:20]};

  assign pc_even_s  = {fch_pc[31:1], 1'b0};
  assign opcode_s   = fch_insn[6:0];
  assign funct3_s   = fch_insn[14:12];
  assign rd_link_s  = (fch_insn[11:7] == 5'd1) || (fch_insn[11:7] == 5'd5);
  assign rs1_link_s = (fch_insn[19:15] == 5'd1) || (fch_insn[19:15] == 5'd5);

  // Instruction classification and link address for the word at fetch
  always_comb begin
    cls_s  = CLS_NONE;
    link_s = pc_even_s + 32'd4;
    if (fch_insn[1:0] == 2'b11) begin
      if (opcode_s == 7'b1101111) begin
        if (rd_link_s) begin
          cls_s = CLS_CALL;
        end else begin
          cls_s = CLS_NONE;
        end
      end else if ((opcode_s == 7'b1100111) && (funct3_s == 3'b000)) begin
        // A link destination wins over a link source: jalr x1,0(x5) is a call.
        if (rd_link_s) begin
          cls_s = CLS_CALL;
        end else if (rs1_link_s) begin
          cls_s = CLS_RET;
        end else begin
          cls_s = CLS_NONE;
        end
      end else begin
        cls_s = CLS_NONE;
      end
    end else begin
`ifdef RAS_EVQ_RVC_EN
      link_s = pc_even_s + 32'd2;
      if ((fch_insn[15:13] == 3'b001) && (fch_insn[1:0] == 2'b01)) begin
        cls_s = CLS_CALL;
      end else if ((fch_insn[15:13] == 3'b100) && (fch_insn[1:0] == 2'b10) &&
                   (fch_insn[6:2] == 5'd0)) begin
        if (fch_insn[12] && (fch_insn[11:7] != 5'd0)) begin
          cls_s = CLS_CALL;
        end else if (!fch_insn[12] && rd_link_s) begin
          cls_s = CLS_RET;
        end else begin
          cls_s = CLS_NONE;
        end
      end else begin
        cls_s = CLS_NONE;
      end
`else
      cls_s = CLS_NONE;
`endif
    end
  end

  assign full_s      = count_r[Q_SIZE];
  assign empty_s     = (count_r == {(Q_SIZE+1){1'b0}});
  assign fch_ready   = !full_s && !wrb_restart_in;
  assign accept_s    = fch_valid && fch_ready;
  assign retire_ok_s = wrb_retire && !empty_s;
  assign underflow_s = wrb_retire && empty_s;

  assign fch_predict_call = accept_s && (cls_s == CLS_CALL);
  assign fch_predict_ret  = accept_s && (cls_s == CLS_RET);
  assign fch_link_addr    = link_s;

  assign head_entry_s = mem_r[head_r];
  assign head_cls_s   = head_entry_s[32:31];
  assign head_link_s  = head_entry_s[30:0];
  assign q_count      = count_r;

  // Occupancy change from this cycle's accept/retire pair
  always_comb begin
    count_next_s = count_r;
    case ({accept_s, retire_ok_s})
      2'b10:   count_next_s = count_r + {{Q_SIZE{1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{Q_SIZE{1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Entry storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[tail_r] <= {cls_s, link_s[31:1]};
    end
  end

  // Queue pointers and occupancy; a restart flushes after the retire has read the head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {Q_SIZE{1'b0}};
      tail_r  <= {Q_SIZE{1'b0}};
      count_r <= {(Q_SIZE+1){1'b0}};
    end else if (wrb_restart_in) begin
      head_r  <= {Q_SIZE{1'b0}};
      tail_r  <= {Q_SIZE{1'b0}};
      count_r <= {(Q_SIZE+1){1'b0}};
    end else begin
      if (accept_s) begin
        tail_r <= tail_r + {{(Q_SIZE-1){1'b0}}, 1'b1};
      end
      if (retire_ok_s) begin
        head_r <= head_r + {{(Q_SIZE-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
    end
  end

  // Commit replay toward the non-speculative RAS, aligned with the forwarded restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrb_commit_call <= 1'b0;
      wrb_commit_ret  <= 1'b0;
      wrb_link_addr   <= 32'd0;
      wrb_restart     <= 1'b0;
      q_underflow     <= 1'b0;
    end else begin
      wrb_commit_call <= retire_ok_s && (head_cls_s == CLS_CALL);
      wrb_commit_ret  <= retire_ok_s && (head_cls_s == CLS_RET);
      wrb_restart     <= wrb_restart_in;
      if (retire_ok_s && (head_cls_s == CLS_CALL)) begin
        wrb_link_addr <= {head_link_s, 1'b0};
      end
      if (underflow_s) begin
        q_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ras_event_queue.sv
// Self-checking bench for ras_event_queue: directed scenarios then random traffic against a queue model.
module tb_ras_event_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fch_valid;
  logic        fch_ready;
  logic [31:0] fch_insn;
  logic [31:0] fch_pc;
  logic        fch_predict_call;
  logic        fch_predict_ret;
  logic [31:0] fch_link_addr;
  logic        wrb_retire;
  logic        wrb_restart_in;
  logic        wrb_commit_call;
  logic        wrb_commit_ret;
  logic [31:0] wrb_link_addr;
  logic        wrb_restart;
  logic [3:0]  q_count;
  logic        q_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cls;
    logic [31:0] link;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_wlink;
  logic        exp_uf;

  ras_event_queue #(.Q_SIZE(3)) dut (
    .clk(clk), .reset(reset),
    .fch_valid(fch_valid), .fch_ready(fch_ready), .fch_insn(fch_insn), .fch_pc(fch_pc),
    .fch_predict_call(fch_predict_call), .fch_predict_ret(fch_predict_ret),
    .fch_link_addr(fch_link_addr),
    .wrb_retire(wrb_retire), .wrb_restart_in(wrb_restart_in),
    .wrb_commit_call(wrb_commit_call), .wrb_commit_ret(wrb_commit_ret),
    .wrb_link_addr(wrb_link_addr), .wrb_restart(wrb_restart),
    .q_count(q_count), .q_underflow(q_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // 0 = none, 1 = call, 2 = return
  function automatic int ref_class(input logic [31:0] w);
    if (w[1:0] == 2'b11) begin
      if (w[6:0] == 7'b1101111) return is_link(w[11:7]) ? 1 : 0;
      if (w[6:0] == 7'b1100111 && w[14:12] == 3'b000) begin
        if (is_link(w[11:7])) return 1;
        if (is_link(w[19:15])) return 2;
      end
      return 0;
    end
`ifdef RAS_EVQ_RVC_EN
    if (w[1:0] == 2'b01 && w[15:13] == 3'b001) return 1;
    if (w[1:0] == 2'b10 && w[15:13] == 3'b100 && w[6:2] == 5'd0) begin
      if (w[12] && w[11:7] != 5'd0) return 1;
      if (!w[12] && is_link(w[11:7])) return 2;
    end
`endif
    return 0;
  endfunction

  function automatic logic [31:0] ref_link(input logic [31:0] w, input logic [31:0] pc);
`ifdef RAS_EVQ_RVC_EN
    if (w[1:0] != 2'b11) return (pc & 32'hFFFF_FFFE) + 32'd2;
`endif
    return (pc & 32'hFFFF_FFFE) + 32'd4;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd2;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    case ($urandom_range(0, 5))
      0: return {20'($urandom), pick_reg(), 7'b1101111};
      1: return {12'($urandom), pick_reg(), 3'b000, pick_reg(), 7'b1100111};
      2: return {12'($urandom), pick_reg(), 3'($urandom_range(1, 7)), pick_reg(), 7'b1100111};
      3: return {16'($urandom), 3'b100, 1'($urandom), pick_reg(), 5'd0, 2'b10};
      4: return {16'($urandom), 3'b001, 11'($urandom), 2'b01};
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at negedge, check fetch-side outputs, advance model, check writeback side.
  task automatic cycle(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ret, input logic rst_in);
    bit   rdy, acc, pc_call, pc_ret;
    int   c;
    ent_t e;
    @(negedge clk);
    fch_valid = v; fch_insn = insn; fch_pc = pc;
    wrb_retire = ret; wrb_restart_in = rst_in;
    #1;
    rdy = (mq.size() < 8) && !rst_in;
    acc = v && rdy;
    c   = ref_class(insn);
    chk("fch_ready", fch_ready, rdy);
    chk("fch_predict_call", fch_predict_call, acc && c == 1);
    chk("fch_predict_ret", fch_predict_ret, acc && c == 2);
    if (acc && c == 1) chk("fch_link_addr", fch_link_addr, ref_link(insn, pc));
    pc_call = 0; pc_ret = 0;
    if (ret) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        pc_call = (e.cls == 1);
        pc_ret  = (e.cls == 2);
        if (pc_call) exp_wlink = e.link;
      end else begin
        exp_uf = 1'b1;
      end
    end
    if (rst_in) begin
      mq.delete();
    end else if (acc) begin
      e.cls = c; e.link = ref_link(insn, pc);
      mq.push_back(e);
    end
    @(posedge clk); #1;
    chk("wrb_commit_call", wrb_commit_call, pc_call);
    chk("wrb_commit_ret", wrb_commit_ret, pc_ret);
    chk("wrb_link_addr", wrb_link_addr, exp_wlink);
    chk("wrb_restart", wrb_restart, rst_in);
    chk("q_count", q_count, mq.size());
    chk("q_underflow", q_underflow, exp_uf);
  endtask

  // Asynchronous reset asserted mid-cycle, then released on a falling edge.
  task automatic do_reset();
    fch_valid = 1'b0; wrb_retire = 1'b0; wrb_restart_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    mq.delete(); exp_wlink = 32'd0; exp_uf = 1'b0;
    chk("rst_q_count", q_count, 32'd0);
    chk("rst_fch_ready", fch_ready, 32'd1);
    chk("rst_commit_call", wrb_commit_call, 32'd0);
    chk("rst_commit_ret", wrb_commit_ret, 32'd0);
    chk("rst_link", wrb_link_addr, 32'd0);
    chk("rst_restart", wrb_restart, 32'd0);
    chk("rst_underflow", q_underflow, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; fch_valid = 1'b0; fch_insn = 32'd0; fch_pc = 32'd0;
    wrb_retire = 1'b0; wrb_restart_in = 1'b0;
    exp_wlink = 32'd0; exp_uf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // jal x1 at 0x1000, then retire it
    cycle(1'b1, 32'h100000EF, 32'h0000_1000, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t1_commit_call", wrb_commit_call, 32'd1);
    chk("t1_link", wrb_link_addr, 32'h0000_1004);

    // jalr x0,0(x1) is a return
    cycle(1'b1, 32'h00008067, 32'h0000_2000, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t2_commit_ret", wrb_commit_ret, 32'd1);

    // Fill to capacity, offer more while full, then drain one
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100000EF, 32'h4000 + 32'(i * 4), 1'b0, 1'b0);
    chk("t3_full_count", q_count, 32'd8);
    cycle(1'b1, 32'h100000EF, 32'h5000, 1'b0, 1'b0);
    cycle(1'b1, 32'h100000EF, 32'h5004, 1'b1, 1'b0);
    chk("t3_after_retire", q_count, 32'd7);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // [CALL, NONE, RETURN] then retire together with restart
    cycle(1'b1, 32'h100000EF, 32'h0000_1000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000013, 32'h0000_1004, 1'b0, 1'b0);
    cycle(1'b1, 32'h00008067, 32'h0000_1008, 1'b0, 1'b0);
    cycle(1'b1, 32'h100000EF, 32'h0000_100C, 1'b1, 1'b1);
    chk("t4_restart", wrb_restart, 32'd1);
    chk("t4_link", wrb_link_addr, 32'h0000_1004);
    chk("t4_count", q_count, 32'd0);

    // Underflow is sticky until reset; reset lands on a pending commit
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_underflow_held", q_underflow, 32'd1);
    cycle(1'b1, 32'h100000EF, 32'h0000_6000, 1'b0, 1'b0);
    cycle(1'b1, 32'h100000EF, 32'h0000_6004, 1'b1, 1'b0);
    do_reset();

    // c.jalr x1 at 0x3000
    cycle(1'b1, 32'h0000_9082, 32'h0000_3000, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle($urandom_range(0, 99) < 75, rand_insn(), $urandom & 32'hFFFF_FFFE,
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
